// File: rtl/counter_cmd_seq.sv
// Command sequencer for the up/down loadable counter: expands LOAD/UP/DOWN/HOLD
// commands into cycle-exact load_n/ce/up_down/data_load control with done reporting.
module counter_cmd_seq #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [WIDTH-1:0]  cmd_data,
    input  logic [STEP_W-1:0] cmd_len,
    input  logic              cmd_sat,
    input  logic              zero,
    input  logic              max_count,
    output logic              load_n,
    output logic              ce,
    output logic              up_down,
    output logic [WIDTH-1:0]  data_load,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] done_steps,
    output logic              sat_hit
);
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_HOLD = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_HOLD} state_t;

    state_t            state;
    logic [STEP_W-1:0] rem;
    logic [STEP_W-1:0] issued;
    logic              sat_q;
    logic              limit;

    // Limit is checked against the live flags so the saturating cycle never wraps.
    assign limit = sat_q && (up_down ? max_count : zero);

    always_comb begin
        cmd_ready = (state == S_IDLE) && !rst;
        busy      = (state != S_IDLE) && !rst;
        load_n    = (state != S_LOAD) || rst;
        ce        = (state == S_RUN) && !limit && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            rem        <= '0;
            issued     <= '0;
            sat_q      <= 1'b0;
            up_down    <= 1'b0;
            data_load  <= '0;
            done       <= 1'b0;
            done_steps <= '0;
            sat_hit    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        issued <= '0;
                        rem    <= cmd_len;
                        sat_q  <= cmd_sat && (cmd_op == OP_UP || cmd_op == OP_DOWN);
                        case (cmd_op)
                            OP_LOAD: begin
                                data_load <= cmd_data;
                                state     <= S_LOAD;
                            end
                            OP_UP, OP_DOWN: begin
                                up_down <= (cmd_op == OP_UP);
                                if (cmd_len == '0) begin
                                    done       <= 1'b1;
                                    done_steps <= '0;
                                    sat_hit    <= 1'b0;
                                end else begin
                                    state <= S_RUN;
                                end
                            end
                            OP_HOLD: begin
                                if (cmd_len == '0) begin
                                    done       <= 1'b1;
                                    done_steps <= '0;
                                    sat_hit    <= 1'b0;
                                end else begin
                                    state <= S_HOLD;
                                end
                            end
                            default: state <= S_IDLE;
                        endcase
                    end
                end
                S_LOAD: begin
                    state      <= S_IDLE;
                    done       <= 1'b1;
                    done_steps <= '0;
                    sat_hit    <= 1'b0;
                end
                S_RUN: begin
                    if (limit) begin
                        state      <= S_IDLE;
                        done       <= 1'b1;
                        done_steps <= issued;
                        sat_hit    <= 1'b1;
                    end else begin
                        issued <= issued + 1'b1;
                        rem    <= rem - 1'b1;
                        if (rem == STEP_W'(1)) begin
                            state      <= S_IDLE;
                            done       <= 1'b1;
                            done_steps <= issued + 1'b1;
                            sat_hit    <= 1'b0;
                        end
                    end
                end
                S_HOLD: begin
                    rem <= rem - 1'b1;
                    if (rem == STEP_W'(1)) begin
                        state      <= S_IDLE;
                        done       <= 1'b1;
                        done_steps <= '0;
                        sat_hit    <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_counter_cmd_seq.sv
// Directed bench for counter_cmd_seq driving a behavioural 4-bit up/down counter.
module tb_counter_cmd_seq;
    localparam int WIDTH  = 4;
    localparam int STEP_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [WIDTH-1:0]  cmd_data;
    logic [STEP_W-1:0] cmd_len;
    logic              cmd_sat;
    logic              zero;
    logic              max_count;
    logic              load_n;
    logic              ce;
    logic              up_down;
    logic [WIDTH-1:0]  data_load;
    logic              busy;
    logic              done;
    logic [STEP_W-1:0] done_steps;
    logic              sat_hit;

    int errors = 0;
    int checks = 0;

    counter_cmd_seq #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_len(cmd_len), .cmd_sat(cmd_sat),
        .zero(zero), .max_count(max_count), .load_n(load_n), .ce(ce),
        .up_down(up_down), .data_load(data_load), .busy(busy), .done(done),
        .done_steps(done_steps), .sat_hit(sat_hit)
    );

    always #5 clk = ~clk;

    // Downstream counter the sequencer controls.
    logic [WIDTH-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst)          cnt <= '0;
        else if (!load_n) cnt <= data_load;
        else if (ce)      cnt <= up_down ? cnt + 1'b1 : cnt - 1'b1;
    end
    assign zero      = (cnt == '0);
    assign max_count = (cnt == '1);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]        op;
        logic [WIDTH-1:0]  data;
        logic [STEP_W-1:0] len;
        logic              sat;
        int                lat;
        int                steps;
        int                sat_e;
        int                cnt_e;
        int                ce_n;
        int                load_cyc;
    } vec_t;

    // Called just before a posedge while the DUT is idle; returns at the negedge of the done cycle.
    task automatic run_cmd(input vec_t v, input int idx);
        int k, nce, nld;
        bit got;
        cmd_op = v.op; cmd_data = v.data; cmd_len = v.len; cmd_sat = v.sat;
        cmd_valid = 1'b1;
        chk($sformatf("v%0d ready", idx), cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        nce = 0; nld = 0; got = 0;
        for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin got = 1; break; end
            if (ce) nce++;
            if (!load_n) begin
                nld++;
                chk($sformatf("v%0d data_load", idx), data_load, v.data);
            end
        end
        if (!got) begin
            chk($sformatf("v%0d done timeout", idx), 0, 1);
        end else begin
            chk($sformatf("v%0d latency", idx), k, v.lat);
            chk($sformatf("v%0d done_steps", idx), done_steps, v.steps);
            chk($sformatf("v%0d sat_hit", idx), sat_hit, v.sat_e);
            chk($sformatf("v%0d count", idx), cnt, v.cnt_e);
            chk($sformatf("v%0d ce cycles", idx), nce, v.ce_n);
            chk($sformatf("v%0d load cycles", idx), nld, v.load_cyc);
            chk($sformatf("v%0d ready in done", idx), cmd_ready, 1);
        end
    endtask

    vec_t vecs[10];
    int ndone;

    initial begin
        //        op     data  len sat lat steps sat cnt ce ld
        vecs[0] = '{2'b00, 4'hA, 8'd0, 1'b0, 2, 0, 0, 10, 0, 1};
        vecs[1] = '{2'b01, 4'h0, 8'd7, 1'b0, 8, 7, 0,  1, 7, 0};
        vecs[2] = '{2'b00, 4'hA, 8'd9, 1'b1, 2, 0, 0, 10, 0, 1};
        vecs[3] = '{2'b01, 4'h0, 8'd7, 1'b1, 7, 5, 1, 15, 5, 0};
        vecs[4] = '{2'b00, 4'h2, 8'd0, 1'b0, 2, 0, 0,  2, 0, 1};
        vecs[5] = '{2'b10, 4'h0, 8'd7, 1'b1, 4, 2, 1,  0, 2, 0};
        vecs[6] = '{2'b10, 4'h0, 8'd0, 1'b0, 1, 0, 0,  0, 0, 0};
        vecs[7] = '{2'b11, 4'h0, 8'd3, 1'b1, 4, 0, 0,  0, 0, 0};
        vecs[8] = '{2'b01, 4'h0, 8'd3, 1'b1, 4, 3, 0,  3, 3, 0};
        vecs[9] = '{2'b10, 4'h0, 8'd5, 1'b0, 6, 5, 0, 14, 5, 0};

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_len = '0; cmd_sat = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst ready low", cmd_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset load_n", load_n, 1);
        chk("reset ce", ce, 0);
        chk("reset up_down", up_down, 0);
        chk("reset data_load", data_load, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset done_steps", done_steps, 0);
        chk("reset sat_hit", sat_hit, 0);
        chk("reset ready", cmd_ready, 1);

        // Commands run back to back: each next one is offered in the previous done cycle.
        foreach (vecs[i]) run_cmd(vecs[i], i);

        // cmd_valid held high through a HOLD len=2: re-accepted only in the done cycle.
        cmd_op = 2'b11; cmd_len = 8'd2; cmd_sat = 1'b0; cmd_valid = 1'b1;
        ndone = 0;
        @(posedge clk); #1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (done) ndone++;
            if (c == 1 || c == 2 || c == 4 || c == 5) begin
                chk($sformatf("held c%0d ready", c), cmd_ready, 0);
                chk($sformatf("held c%0d ce", c), ce, 0);
            end
            if (c == 3) begin
                chk("held c3 done", done, 1);
                chk("held c3 ready", cmd_ready, 1);
            end
            if (c == 4) chk("held c4 done one cycle", done, 0);
            if (c == 6) chk("held c6 done", done, 1);
            if (c == 3) begin
                @(posedge clk); #1;
                cmd_valid = 1'b0;
            end
        end
        chk("held done count", ndone, 2);
        chk("held count unchanged", cnt, 14);

        // Reset for 3 cycles in the middle of a long UP run.
        @(negedge clk);
        cmd_op = 2'b01; cmd_len = 8'd20; cmd_sat = 1'b0; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("mid rst%0d ce", c), ce, 0);
            chk($sformatf("mid rst%0d load_n", c), load_n, 1);
            chk($sformatf("mid rst%0d busy", c), busy, 0);
            chk($sformatf("mid rst%0d ready", c), cmd_ready, 0);
            chk($sformatf("mid rst%0d done", c), done, 0);
            if (c < 2) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post rst ready", cmd_ready, 1);
        chk("post rst busy", busy, 0);
        chk("post rst done_steps", done_steps, 0);
        ndone = 0;
        for (int c = 0; c < 25; c++) begin
            if (done) ndone++;
            if (ce) ndone++;
            @(negedge clk);
        end
        chk("post rst no done/ce", ndone, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
